// File: rtl/filter_window_5x5.sv
// filter_window_5x5: raster pixel stream to 5x5 sliding window via 4 line buffers
module filter_window_5x5 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_x00, o_x01, o_x02, o_x03, o_x04,
  output logic [DATA_WIDTH-1:0] o_x10, o_x11, o_x12, o_x13, o_x14,
  output logic [DATA_WIDTH-1:0] o_x20, o_x21, o_x22, o_x23, o_x24,
  output logic [DATA_WIDTH-1:0] o_x30, o_x31, o_x32, o_x33, o_x34,
  output logic [DATA_WIDTH-1:0] o_x40, o_x41, o_x42, o_x43, o_x44
);
  localparam int CW = $clog2(IMG_WIDTH);
  logic [CW-1:0]         col, pos_col, col_nxt;
  logic [2:0]            row, pos_row, row_nxt;
  logic                  wrap;
  logic [DATA_WIDTH-1:0] lb  [4][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [5][5];
  logic [DATA_WIDTH-1:0] cv  [5];
  // Position of the incoming pixel (sof forces 0,0), next counters and the new column
  always_comb begin
    pos_col = i_sof ? '0 : col;
    pos_row = i_sof ? '0 : row;
    wrap    = pos_col == CW'(IMG_WIDTH - 1);
    col_nxt = wrap ? '0 : pos_col + CW'(1);
    row_nxt = (wrap && pos_row != 3'd4) ? pos_row + 3'd1 : pos_row;
    for (int i = 0; i < 4; i++) cv[i] = lb[i][pos_col];
    cv[4] = i_pixel;
  end
  // Counters, valid flag and window shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      o_valid <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) win[r][c] <= '0;
    end else begin
      o_valid <= i_valid && pos_row == 3'd4 && pos_col >= CW'(4);
      if (i_valid) begin
        col <= col_nxt;
        row <= row_nxt;
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) win[r][c] <= win[r][c+1];
          win[r][4] <= cv[r];
        end
      end
    end
  end
  // Line buffers shift up one line at the current column; contents need no reset
  always_ff @(posedge clk) begin
    if (i_valid && !rst) begin
      for (int i = 0; i < 3; i++) lb[i][pos_col] <= lb[i+1][pos_col];
      lb[3][pos_col] <= i_pixel;
    end
  end
  assign {o_x00, o_x01, o_x02, o_x03, o_x04} = {win[0][0], win[0][1], win[0][2], win[0][3], win[0][4]};
  assign {o_x10, o_x11, o_x12, o_x13, o_x14} = {win[1][0], win[1][1], win[1][2], win[1][3], win[1][4]};
  assign {o_x20, o_x21, o_x22, o_x23, o_x24} = {win[2][0], win[2][1], win[2][2], win[2][3], win[2][4]};
  assign {o_x30, o_x31, o_x32, o_x33, o_x34} = {win[3][0], win[3][1], win[3][2], win[3][3], win[3][4]};
  assign {o_x40, o_x41, o_x42, o_x43, o_x44} = {win[4][0], win[4][1], win[4][2], win[4][3], win[4][4]};
endmodule

// File: tb/tb_filter_window_5x5.sv
// tb_filter_window_5x5: directed tests for the 5x5 window generator at widths 8 and 5
module tb_filter_window_5x5;
  logic clk = 1'b0, rst = 1'b1;
  logic iv = 1'b0, isof = 1'b0, iv5 = 1'b0, isof5 = 1'b0;
  logic [7:0] ipix = '0, ipix5 = '0;
  logic ov, ov5;
  logic [7:0] ox [5][5];
  logic [7:0] ox5 [5][5];
  logic [199:0] obs, obs5;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  filter_window_5x5 #(.DATA_WIDTH(8), .IMG_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_valid(iv), .i_sof(isof), .i_pixel(ipix), .o_valid(ov),
    .o_x00(ox[0][0]), .o_x01(ox[0][1]), .o_x02(ox[0][2]), .o_x03(ox[0][3]), .o_x04(ox[0][4]),
    .o_x10(ox[1][0]), .o_x11(ox[1][1]), .o_x12(ox[1][2]), .o_x13(ox[1][3]), .o_x14(ox[1][4]),
    .o_x20(ox[2][0]), .o_x21(ox[2][1]), .o_x22(ox[2][2]), .o_x23(ox[2][3]), .o_x24(ox[2][4]),
    .o_x30(ox[3][0]), .o_x31(ox[3][1]), .o_x32(ox[3][2]), .o_x33(ox[3][3]), .o_x34(ox[3][4]),
    .o_x40(ox[4][0]), .o_x41(ox[4][1]), .o_x42(ox[4][2]), .o_x43(ox[4][3]), .o_x44(ox[4][4]));
  filter_window_5x5 #(.DATA_WIDTH(8), .IMG_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .i_valid(iv5), .i_sof(isof5), .i_pixel(ipix5), .o_valid(ov5),
    .o_x00(ox5[0][0]), .o_x01(ox5[0][1]), .o_x02(ox5[0][2]), .o_x03(ox5[0][3]), .o_x04(ox5[0][4]),
    .o_x10(ox5[1][0]), .o_x11(ox5[1][1]), .o_x12(ox5[1][2]), .o_x13(ox5[1][3]), .o_x14(ox5[1][4]),
    .o_x20(ox5[2][0]), .o_x21(ox5[2][1]), .o_x22(ox5[2][2]), .o_x23(ox5[2][3]), .o_x24(ox5[2][4]),
    .o_x30(ox5[3][0]), .o_x31(ox5[3][1]), .o_x32(ox5[3][2]), .o_x33(ox5[3][3]), .o_x34(ox5[3][4]),
    .o_x40(ox5[4][0]), .o_x41(ox5[4][1]), .o_x42(ox5[4][2]), .o_x43(ox5[4][3]), .o_x44(ox5[4][4]));
  // Flatten both windows, row-major, for whole-window comparisons
  always_comb begin
    obs = '0;
    obs5 = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        obs[(r*5+c)*8 +: 8]  = ox[r][c];
        obs5[(r*5+c)*8 +: 8] = ox5[r][c];
      end
  end
  // Window expected when pixel (R,C) of a frame whose pixels are b + row*16 + col was just accepted
  function automatic logic [199:0] exp_win(input int R, input int C, input logic [7:0] b);
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) v[(r*5+c)*8 +: 8] = b + 8'((R - 4 + r) * 16 + C - 4 + c);
    return v;
  endfunction
  task automatic send(input logic [7:0] p, input logic s);
    iv = 1'b1; isof = s; ipix = p;
    @(posedge clk); #1;
    iv = 1'b0; isof = 1'b0;
  endtask
  task automatic send5(input logic [7:0] p, input logic s);
    iv5 = 1'b1; isof5 = s; ipix5 = p;
    @(posedge clk); #1;
    iv5 = 1'b0; isof5 = 1'b0;
  endtask
  task automatic idle(input logic s);
    iv = 1'b0; isof = s;
    @(posedge clk); #1;
    isof = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; iv = 1'b1; isof = 1'b1; ipix = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", ov); end
    if (obs !== '0) begin n_fail++; $display("FAIL reset_window got %h exp 0", obs); end
    if (ov5 !== 1'b0) begin n_fail++; $display("FAIL reset_valid5 got %b exp 0", ov5); end
    if (obs5 !== '0) begin n_fail++; $display("FAIL reset_window5 got %h exp 0", obs5); end
    rst = 1'b0; iv = 1'b0; isof = 1'b0;
  endtask
  task automatic test_frame();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        logic e;
        send(8'(r*16+c), r == 0 && c == 0);
        e = r >= 4 && c >= 4;
        n_checks++;
        if (ov !== e) begin n_fail++; $display("FAIL frame_valid R=%0d C=%0d got %b exp %b", r, c, ov, e); end
        if (e) begin
          n_checks++;
          if (obs !== exp_win(r, c, 8'h00)) begin
            n_fail++; $display("FAIL frame_window R=%0d C=%0d got %h exp %h", r, c, obs, exp_win(r, c, 8'h00));
          end
        end
      end
  endtask
  task automatic test_gaps();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        logic e;
        if ($urandom_range(0, 2) == 0)
          repeat ($urandom_range(1, 3)) begin
            idle(1'b1);
            n_checks++;
            if (ov !== 1'b0) begin n_fail++; $display("FAIL gap_valid R=%0d C=%0d got %b exp 0", r, c, ov); end
          end
        send(8'(r*16+c), r == 0 && c == 0);
        e = r >= 4 && c >= 4;
        n_checks++;
        if (ov !== e) begin n_fail++; $display("FAIL gaps_valid R=%0d C=%0d got %b exp %b", r, c, ov, e); end
        if (e) begin
          n_checks++;
          if (obs !== exp_win(r, c, 8'h00)) begin
            n_fail++; $display("FAIL gaps_window R=%0d C=%0d got %h exp %h", r, c, obs, exp_win(r, c, 8'h00));
          end
        end
      end
  endtask
  task automatic test_sof_restart();
    for (int i = 0; i < 5*8+3; i++) send(8'((i/8)*16 + i%8), i == 0);
    for (int i = 0; i < 37; i++) begin
      int r, c;
      logic e;
      r = i / 8; c = i % 8;
      send(8'h80 + 8'(r*16+c), i == 0);
      e = r == 4 && c == 4;
      n_checks++;
      if (ov !== e) begin n_fail++; $display("FAIL sof_valid R=%0d C=%0d got %b exp %b", r, c, ov, e); end
      if (e) begin
        n_checks += 2;
        if (ox[0][0] !== 8'h80) begin n_fail++; $display("FAIL sof_x00 got %h exp 80", ox[0][0]); end
        if (obs !== exp_win(4, 4, 8'h80)) begin
          n_fail++; $display("FAIL sof_window got %h exp %h", obs, exp_win(4, 4, 8'h80));
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 6*8+3; i++) send(8'((i/8)*16 + i%8), i == 0);
    rst = 1'b1; iv = 1'b1; ipix = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0; iv = 1'b0;
    n_checks += 2;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", ov); end
    if (obs !== '0) begin n_fail++; $display("FAIL rstmid_window got %h exp 0", obs); end
    for (int i = 0; i < 37; i++) begin
      logic e;
      send(8'h80 + 8'((i/8)*16 + i%8), 1'b0);
      e = i == 36;
      n_checks++;
      if (ov !== e) begin n_fail++; $display("FAIL rstmid_count n=%0d got %b exp %b", i + 1, ov, e); end
      if (e) begin
        n_checks++;
        if (obs !== exp_win(4, 4, 8'h80)) begin
          n_fail++; $display("FAIL rstmid_window2 got %h exp %h", obs, exp_win(4, 4, 8'h80));
        end
      end
    end
  endtask
  task automatic test_min_width();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 5; c++) begin
        logic e;
        send5(8'(r*16+c), r == 0 && c == 0);
        e = r >= 4 && c == 4;
        n_checks++;
        if (ov5 !== e) begin n_fail++; $display("FAIL w5_valid R=%0d C=%0d got %b exp %b", r, c, ov5, e); end
        if (e) begin
          n_checks += 2;
          if (ox5[4][4] !== 8'(r*16+4)) begin n_fail++; $display("FAIL w5_x44 R=%0d got %h exp %h", r, ox5[4][4], 8'(r*16+4)); end
          if (obs5 !== exp_win(r, 4, 8'h00)) begin
            n_fail++; $display("FAIL w5_window R=%0d got %h exp %h", r, obs5, exp_win(r, 4, 8'h00));
          end
        end
      end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_sof_restart();
    test_reset_mid();
    test_min_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
